// File: rtl/dll_pkg.sv
// Shared widths, sequence-number type and helpers for the DLL receive path.
package dll_pkg;

  localparam int unsigned TLP_W      = 1196;
  localparam int unsigned DLLP_W     = 48;
  localparam int unsigned SEQ_W      = 12;
  // Largest backward distance still treated as an already-received duplicate.
  localparam int unsigned DUP_WINDOW = 2048;

  typedef logic [SEQ_W-1:0] seq_t;

  // Outcome of the sequence check for one received TLP.
  typedef enum logic [2:0] {
    TLP_NONE,
    TLP_NAK,
    TLP_OVERFLOW,
    TLP_ACCEPT,
    TLP_DUP
  } tlp_act_e;

  // Modular distance a - b over the 12-bit sequence space.
  function automatic seq_t seq_dist(input seq_t a, input seq_t b);
    return a - b;
  endfunction

endpackage

// File: rtl/dll_rx_tlp_fifo.sv
// First-word-fall-through buffer for in-order TLPs awaiting the transaction layer.
module dll_rx_tlp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty;

  // Head is forced to zero when empty so the bus is quiet after reset.
  assign head_c  = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dll_rx_demux.sv
// Splits received frames into DLLPs and TLPs, sequence-checks TLPs and raises Ack/Nak.
module dll_rx_demux
  import dll_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dl_active_i,
  input  logic [TLP_W-1:0]  rx_data_i,
  input  logic              rx_valid_i,
  input  logic              rx_is_dllp_i,
  input  logic              rx_crc_err_i,
  output logic [DLLP_W-1:0] dllp_o,
  output logic              dllp_valid_o,
  output logic [TLP_W-1:0]  tlp_o,
  output logic              tlp_valid_o,
  input  logic              tlp_ready_i,
  output logic              ack_req_o,
  output logic              nak_req_o,
  output logic [SEQ_W-1:0]  ackNak_seq_o,
  output logic              overflow_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  seq_t              next_seq_q;
  seq_t              next_seq_d;
  logic              nak_sched_q;
  logic              nak_sched_d;
  logic [DLLP_W-1:0] dllp_d;
  logic              dllp_valid_d;
  logic              ack_d;
  logic              nak_d;
  seq_t              acknak_seq_d;
  logic              overflow_d;

  seq_t              tlp_seq;
  seq_t              tlp_dist;
  tlp_act_e          tlp_act;
  logic              fifo_push;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;

  assign tlp_seq  = seq_t'(rx_data_i[SEQ_W-1:0]);
  assign tlp_dist = seq_dist(next_seq_q, tlp_seq);

  // Classify a received TLP; CRC errors win over any sequence information.
  always_comb begin
    tlp_act = TLP_NONE;
    if (dl_active_i && rx_valid_i && !rx_is_dllp_i) begin
      if (rx_crc_err_i) begin
        tlp_act = TLP_NAK;
      end else if (tlp_dist == '0) begin
        tlp_act = fifo_full ? TLP_OVERFLOW : TLP_ACCEPT;
      end else if (tlp_dist <= seq_t'(DUP_WINDOW)) begin
        tlp_act = TLP_DUP;
      end else begin
        tlp_act = TLP_NAK;
      end
    end
  end

  // Next-state and registered-output values for sequence and Ack/Nak tracking.
  always_comb begin
    next_seq_d   = next_seq_q;
    nak_sched_d  = nak_sched_q;
    dllp_d       = dllp_o;
    dllp_valid_d = 1'b0;
    ack_d        = 1'b0;
    nak_d        = 1'b0;
    acknak_seq_d = ackNak_seq_o;
    overflow_d   = 1'b0;
    fifo_push    = 1'b0;

    if (!dl_active_i) begin
      next_seq_d  = '0;
      nak_sched_d = 1'b0;
    end else if (rx_valid_i && rx_is_dllp_i) begin
      if (!rx_crc_err_i) begin
        dllp_d       = rx_data_i[DLLP_W-1:0];
        dllp_valid_d = 1'b1;
      end
    end else begin
      unique case (tlp_act)
        TLP_NAK: begin
          // Only one Nak outstanding until the expected TLP finally arrives.
          if (!nak_sched_q) begin
            nak_d        = 1'b1;
            acknak_seq_d = next_seq_q - seq_t'(1);
            nak_sched_d  = 1'b1;
          end
        end
        TLP_OVERFLOW: begin
          // Leave the expected sequence alone so the replay is accepted later.
          overflow_d = 1'b1;
        end
        TLP_ACCEPT: begin
          fifo_push    = 1'b1;
          next_seq_d   = next_seq_q + seq_t'(1);
          nak_sched_d  = 1'b0;
          ack_d        = 1'b1;
          acknak_seq_d = tlp_seq;
        end
        TLP_DUP: begin
          ack_d        = 1'b1;
          acknak_seq_d = next_seq_q - seq_t'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_seq_q   <= '0;
      nak_sched_q  <= 1'b0;
      dllp_o       <= '0;
      dllp_valid_o <= 1'b0;
      ack_req_o    <= 1'b0;
      nak_req_o    <= 1'b0;
      ackNak_seq_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      next_seq_q   <= next_seq_d;
      nak_sched_q  <= nak_sched_d;
      dllp_o       <= dllp_d;
      dllp_valid_o <= dllp_valid_d;
      ack_req_o    <= ack_d;
      nak_req_o    <= nak_d;
      ackNak_seq_o <= acknak_seq_d;
      overflow_o   <= overflow_d;
    end
  end

  // Occupancy before any same-cycle pop decides overflow.
  dll_rx_tlp_fifo #(
    .WIDTH (TLP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tlp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (rx_data_i),
    .pop     (tlp_ready_i),
    .head_c  (tlp_o),
    .full_c  (fifo_full),
    .count   (fifo_count)
  );

  assign tlp_valid_o = (fifo_count != '0);

endmodule

// File: tb/tb_dll_rx_demux.sv
// Randomized and directed bench for dll_rx_demux against a queue-based reference model.
module tb_dll_rx_demux;
  import dll_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              dl_active_i;
  logic [TLP_W-1:0]  rx_data_i;
  logic              rx_valid_i;
  logic              rx_is_dllp_i;
  logic              rx_crc_err_i;
  logic [DLLP_W-1:0] dllp_o;
  logic              dllp_valid_o;
  logic [TLP_W-1:0]  tlp_o;
  logic              tlp_valid_o;
  logic              tlp_ready_i;
  logic              ack_req_o;
  logic              nak_req_o;
  logic [SEQ_W-1:0]  ackNak_seq_o;
  logic              overflow_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int                m_next;
  bit                m_nak;
  logic [DLLP_W-1:0] m_dllp;
  logic [SEQ_W-1:0]  m_acknak;
  logic [TLP_W-1:0]  m_q [$];

  dll_rx_demux #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .dl_active_i  (dl_active_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .rx_is_dllp_i (rx_is_dllp_i),
    .rx_crc_err_i (rx_crc_err_i),
    .dllp_o       (dllp_o),
    .dllp_valid_o (dllp_valid_o),
    .tlp_o        (tlp_o),
    .tlp_valid_o  (tlp_valid_o),
    .tlp_ready_i  (tlp_ready_i),
    .ack_req_o    (ack_req_o),
    .nak_req_o    (nak_req_o),
    .ackNak_seq_o (ackNak_seq_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TLP_W-1:0] got,
                       input logic [TLP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got(low96)=%h exp(low96)=%h t=%0t", tag, got[95:0], exp[95:0], $time);
    end
  endtask

  function automatic logic [TLP_W-1:0] rand_tlp(input int seq);
    logic [TLP_W-1:0] r;
    r = '0;
    for (int i = 0; i < 38; i++) r = (r << 32) | TLP_W'($urandom);
    r[SEQ_W-1:0] = SEQ_W'(seq);
    return r;
  endfunction

  task automatic model_clear();
    m_next   = 0;
    m_nak    = 0;
    m_dllp   = '0;
    m_acknak = '0;
    m_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dllp"},   dllp_o, '0);
    check({tag, "_dllpv"},  dllp_valid_o, '0);
    check({tag, "_tlp"},    tlp_o, '0);
    check({tag, "_tlpv"},   tlp_valid_o, '0);
    check({tag, "_ack"},    ack_req_o, '0);
    check({tag, "_nak"},    nak_req_o, '0);
    check({tag, "_seq"},    ackNak_seq_o, '0);
    check({tag, "_ovf"},    overflow_o, '0);
  endtask

  // One clock: drive at negedge, predict, advance, compare at the following negedge.
  task automatic step(input bit v, input bit dl, input bit crc,
                      input logic [TLP_W-1:0] data, input bit rdy, input bit act);
    bit e_ack, e_nak, e_ovf, e_dv, do_push;
    int pre, seq, d;
    rx_valid_i   = v;
    rx_is_dllp_i = dl;
    rx_crc_err_i = crc;
    rx_data_i    = data;
    tlp_ready_i  = rdy;
    dl_active_i  = act;

    check("tlp_valid", tlp_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) check("tlp_data", tlp_o, m_q[0]);

    e_ack = 0; e_nak = 0; e_ovf = 0; e_dv = 0; do_push = 0;
    pre = m_q.size();
    if (!act) begin
      m_next = 0;
      m_nak  = 0;
    end else if (v && dl) begin
      if (!crc) begin
        e_dv   = 1;
        m_dllp = data[DLLP_W-1:0];
      end
    end else if (v) begin
      seq = int'(data[SEQ_W-1:0]);
      d   = (m_next - seq + 4096) % 4096;
      if (crc || d > 2048) begin
        if (!m_nak) begin
          e_nak    = 1;
          m_acknak = SEQ_W'((m_next + 4095) % 4096);
          m_nak    = 1;
        end
      end else if (d == 0 && pre == DEPTH) begin
        e_ovf = 1;
      end else if (d == 0) begin
        do_push  = 1;
        m_next   = (m_next + 1) % 4096;
        m_nak    = 0;
        e_ack    = 1;
        m_acknak = SEQ_W'(seq);
      end else begin
        e_ack    = 1;
        m_acknak = SEQ_W'((m_next + 4095) % 4096);
      end
    end
    if (rdy && pre > 0) void'(m_q.pop_front());
    if (do_push) m_q.push_back(data);

    @(posedge clk);
    @(negedge clk);
    check("dllp_valid", dllp_valid_o, e_dv);
    check("dllp", dllp_o, m_dllp);
    check("ack", ack_req_o, e_ack);
    check("nak", nak_req_o, e_nak);
    check("acknak_seq", ackNak_seq_o, m_acknak);
    check("overflow", overflow_o, e_ovf);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, '0, rdy, 1);
  endtask

  task automatic send_tlp(input int seq, input bit crc, input bit rdy);
    step(1, 0, crc, rand_tlp(seq), rdy, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_clear();
    check_all_zero("reset");
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1);
  endtask

  initial begin
    logic [TLP_W-1:0] dllp_frame;
    int seq;
    rst = 1'b1; dl_active_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    rx_is_dllp_i = 1'b0; rx_crc_err_i = 1'b0; tlp_ready_i = 1'b0;
    model_clear();
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    do_reset();

    // Back-to-back in-order TLPs
    for (int s = 0; s < 3; s++) send_tlp(s, 0, 1);
    drain();
    send_tlp(2, 0, 1);            // duplicate confirms expected seq is 3
    send_tlp(3, 0, 1);
    drain();

    // DLLP pass-through, then a corrupted DLLP that must be discarded
    dllp_frame = '0;
    dllp_frame[DLLP_W-1:0] = 48'hA5A5_0000_1234;
    step(1, 1, 0, dllp_frame, 1, 1);
    step(1, 1, 1, rand_tlp(7), 1, 1);
    idle(1);

    // Lost TLP -> single Nak, recovery clears it
    do_reset();
    send_tlp(0, 0, 1);
    send_tlp(1, 0, 1);
    send_tlp(3, 0, 1);
    send_tlp(4, 0, 1);
    send_tlp(2, 0, 1);
    send_tlp(9, 0, 1);            // new Nak allowed again
    send_tlp(3, 1, 1);            // CRC error while Nak outstanding
    drain();

    // Duplicate after five accepts
    do_reset();
    for (int s = 0; s < 5; s++) send_tlp(s, 0, 1);
    send_tlp(2, 0, 0);
    drain();

    // Overflow with a stalled consumer, replay after draining
    do_reset();
    for (int s = 0; s < 5; s++) send_tlp(s, 0, 0);
    idle(0);
    drain();
    send_tlp(4, 0, 1);
    drain();

    // Sequence wrap
    do_reset();
    for (int s = 0; s < 4095; s++) send_tlp(s, 0, 1);
    send_tlp(4095, 0, 1);
    send_tlp(0, 0, 0);
    send_tlp(1, 0, 0);

    // Reset in the middle of traffic
    rx_valid_i = 1'b1;
    rx_data_i  = rand_tlp(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit act, v, dl, crc, rdy;
      act = ($urandom_range(0, 99) >= 3);
      v   = ($urandom_range(0, 9) < 7);
      dl  = ($urandom_range(0, 9) < 2);
      crc = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      r   = $urandom_range(0, 9);
      if (r < 6)      seq = m_next;
      else if (r < 8) seq = (m_next + 4095 - $urandom_range(0, 3)) % 4096;
      else if (r < 9) seq = (m_next + 1 + $urandom_range(0, 5)) % 4096;
      else            seq = $urandom_range(0, 4095);
      step(v, dl, crc, rand_tlp(seq), rdy, act);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
